// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan controller slice.
package seg_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_MAX    = 9;
    localparam int MAX_DIGITS = 64;

    typedef logic [BCD_W-1:0] bcd_t;

    // All-ones anode mask of n bits; callers cast it down to their own width.
    function automatic logic [MAX_DIGITS-1:0] anodes_off(input int n);
        return (MAX_DIGITS'(1) << n) - MAX_DIGITS'(1);
    endfunction

    function automatic logic is_valid_bcd(input bcd_t d);
        return d <= BCD_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Free-running divide-by-DIV counter producing a one-cycle tick on the last count.
module seg_scan_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count_reg;

    assign tick = (count_reg == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scanner for a common-anode 7-segment display with tear-free frame
// commit, leading-zero suppression and all-off dead time between digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DIGIT_HZ   = 1000,
    parameter int DEAD_CYC   = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lz_sup,
    output logic [BCD_W-1:0]              bcd_o,
    output logic                          blank_o,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_o
);

    localparam int DIV    = CLK_HZ / DIGIT_HZ;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = NUM_DIGITS'(anodes_off(NUM_DIGITS));

    if (DIV < DEAD_CYC + 2) begin : g_div_check
        $error("seg_scan_ctrl: CLK_HZ/DIGIT_HZ must be at least DEAD_CYC+2");
    end

    logic tick;

    seg_scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic [DEAD_W-1:0]             dead_cnt_reg, dead_cnt_next;
    logic [BCD_W*NUM_DIGITS-1:0]   active_digits_reg, active_digits_next;
    logic [NUM_DIGITS-1:0]         active_en_reg, active_en_next;
    logic [BCD_W*NUM_DIGITS-1:0]   pend_digits_reg;
    logic [NUM_DIGITS-1:0]         pend_en_reg;
    logic                          pend_flag_reg, pend_flag_next;
    logic [NUM_DIGITS-1:0]         an_reg, an_next;
    logic [BCD_W-1:0]              bcd_reg, bcd_next;
    logic                          blank_reg, blank_next;
    logic                          frame_reg;
    logic                          wrap, commit;
    logic [NUM_DIGITS-1:0]         digit_blank;
    logic [NUM_DIGITS-1:0]         lz_blank;
    logic [NUM_DIGITS:1]           zero_above;
    logic [NUM_DIGITS-1:0]         one_hot;

    assign wrap   = tick && (idx_reg == IDX_W'(NUM_DIGITS - 1));
    // A load coinciding with the wrap tick bypasses the pending registers.
    assign commit = wrap && (pend_flag_reg || load);

    always_comb begin
        idx_next       = idx_reg;
        dead_cnt_next  = dead_cnt_reg;
        pend_flag_next = pend_flag_reg;
        if (tick) begin
            idx_next      = wrap ? '0 : idx_reg + IDX_W'(1);
            dead_cnt_next = DEAD_W'(DEAD_CYC);
        end else if (dead_cnt_reg != '0) begin
            dead_cnt_next = dead_cnt_reg - DEAD_W'(1);
        end
        if (commit) begin
            pend_flag_next = 1'b0;
        end else if (load) begin
            pend_flag_next = 1'b1;
        end
    end

    always_comb begin
        active_digits_next = active_digits_reg;
        active_en_next     = active_en_reg;
        if (commit) begin
            active_digits_next = load ? digits_i : pend_digits_reg;
            active_en_next     = load ? digit_en : pend_en_reg;
        end
    end

    // Blanking is evaluated on the frame that will be active after this edge.
    assign zero_above[NUM_DIGITS] = 1'b1;
    assign lz_blank[0]            = 1'b0;

    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
        assign zero_above[gi] = zero_above[gi+1] &
                                (active_digits_next[gi*BCD_W +: BCD_W] == '0);
        assign lz_blank[gi]   = lz_sup & zero_above[gi];
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        assign digit_blank[gi] = !active_en_next[gi] ||
                                 !is_valid_bcd(active_digits_next[gi*BCD_W +: BCD_W]) ||
                                 lz_blank[gi];
    end

    always_comb begin
        one_hot           = '0;
        one_hot[idx_next] = 1'b1;
        bcd_next          = active_digits_next[idx_next*BCD_W +: BCD_W];
        blank_next        = digit_blank[idx_next] || (dead_cnt_next != '0);
        an_next           = blank_next ? ANODES_OFF : ~one_hot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg           <= '0;
            dead_cnt_reg      <= DEAD_W'(DEAD_CYC);
            active_digits_reg <= '0;
            active_en_reg     <= '0;
            pend_digits_reg   <= '0;
            pend_en_reg       <= '0;
            pend_flag_reg     <= 1'b0;
            an_reg            <= ANODES_OFF;
            bcd_reg           <= '0;
            blank_reg         <= 1'b1;
            frame_reg         <= 1'b0;
        end else begin
            idx_reg           <= idx_next;
            dead_cnt_reg      <= dead_cnt_next;
            active_digits_reg <= active_digits_next;
            active_en_reg     <= active_en_next;
            pend_flag_reg     <= pend_flag_next;
            an_reg            <= an_next;
            bcd_reg           <= bcd_next;
            blank_reg         <= blank_next;
            frame_reg         <= commit;
            if (load) begin
                pend_digits_reg <= digits_i;
                pend_en_reg     <= digit_en;
            end
        end
    end

    assign an      = an_reg;
    assign bcd_o   = bcd_reg;
    assign blank_o = blank_reg;
    assign frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: loaded frames are queued with the wrap
// edge at which they must appear and compared against the scan outputs.
module tb_seg_scan_ctrl;

    localparam int ND   = 8;
    localparam int DIV  = 10;
    localparam int DEAD = 2;
    localparam int FRM  = ND * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [31:0] digits_i;
    logic [7:0]  digit_en;
    logic        lz_sup;
    logic [3:0]  bcd_o;
    logic        blank_o;
    logic [7:0]  an;
    logic        frame_o;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (1000),
        .DIGIT_HZ   (100),
        .DEAD_CYC   (DEAD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .digits_i (digits_i),
        .digit_en (digit_en),
        .lz_sup   (lz_sup),
        .bcd_o    (bcd_o),
        .blank_o  (blank_o),
        .an       (an),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          target;
        logic [31:0] digits;
        logic [7:0]  en;
        logic        lz;
    } frame_t;

    frame_t sb[$];
    frame_t cur = '{target: 0, digits: 32'h0, en: 8'h0, lz: 1'b0};
    int     cyc = 0;
    int     n_chk = 0;
    int     n_err = 0;
    bit     mon_en = 1'b0;

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive load so that it is sampled on posedge e; the frame is due at the next wrap.
    task automatic load_at(input int e, input logic [31:0] d, input logic [7:0] en, input logic lz);
        frame_t f;
        wait_cyc(e - 1);
        load     = 1'b1;
        digits_i = d;
        digit_en = en;
        f.target = ((e + FRM - 1) / FRM) * FRM;
        f.digits = d;
        f.en     = en;
        f.lz     = lz;
        sb.push_back(f);
        $display("load  @%0d: digits=%h en=%h due at %0d", e, d, en, f.target);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic set_lz_at(input int e, input logic v);
        wait_cyc(e - 1);
        lz_sup = v;
    endtask

    // Monitor: sample after posedge n at the boundaries of each digit slot.
    always @(negedge clk) begin : mon
        int          n, r, k;
        logic        exp_frame, dead, blk;
        logic [3:0]  d;
        logic [31:0] above;
        logic [7:0]  sel, exp_an;
        if (rst_n && mon_en && cyc > 0) begin
            n = cyc;
            r = n % DIV;
            k = (n / DIV) % ND;
            if (r == 0) begin
                exp_frame = 1'b0;
                if (n % FRM == 0) begin
                    while (sb.size() > 0 && sb[0].target == n) begin
                        cur       = sb.pop_front();
                        exp_frame = 1'b1;
                    end
                end
                check("frame_o", 32'(frame_o), 32'(exp_frame));
                if (exp_frame)
                    $display("frame @%0d: digits=%h en=%h lz=%0d", n, cur.digits, cur.en, cur.lz);
            end
            if (r < DEAD + 1 || r == DIV - 1) begin
                d      = cur.digits[4*k +: 4];
                above  = cur.digits >> (4 * k);
                dead   = (r < DEAD);
                blk    = !cur.en[k] || (d > 4'd9) || (cur.lz && k != 0 && above == 32'h0);
                sel    = 8'h01 << k;
                exp_an = (dead || blk) ? 8'hFF : ~sel;
                check("an",      32'(an),      32'(exp_an));
                check("blank_o", 32'(blank_o), 32'(dead || blk));
                check("bcd_o",   32'(bcd_o),   32'(d));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        digits_i = 32'h0;
        digit_en = 8'h0;
        lz_sup   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an",    32'(an),          32'hFF);
        check("rst_blank", 32'(blank_o),     32'h1);
        check("rst_bcd",   32'(bcd_o),       32'h0);
        check("rst_frame", 32'(frame_o),     32'h0);
        check("rst_idx",   32'(dut.idx_reg), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        load_at(5, 32'h87654321, 8'hFF, 1'b0);
        wait_cyc(9);
        check("idx_before_tick", 32'(dut.idx_reg), 32'h0);
        wait_cyc(10);
        check("idx_first_tick", 32'(dut.idx_reg), 32'h1);

        // Mid-frame load while digit 3 is on screen.
        load_at(115, 32'h11111111, 8'hFF, 1'b0);
        load_at(200, 32'h00000400, 8'hFF, 1'b1);
        set_lz_at(240, 1'b1);
        load_at(300, 32'h0000000F, 8'hFF, 1'b1);
        // Load on the wrap edge, then two loads before the following wrap.
        set_lz_at(400, 1'b0);
        load_at(400, 32'hA3572468, 8'hFF, 1'b0);
        load_at(420, 32'h99999999, 8'hFF, 1'b0);
        load_at(450, 32'h02468135, 8'h7E, 1'b0);

        // Pending load discarded by a mid-scan reset.
        load_at(570, 32'h55555555, 8'hFF, 1'b0);
        wait_cyc(575);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_an",    32'(an),          32'hFF);
        check("mid_rst_blank", 32'(blank_o),     32'h1);
        check("mid_rst_bcd",   32'(bcd_o),       32'h0);
        check("mid_rst_frame", 32'(frame_o),     32'h0);
        check("mid_rst_idx",   32'(dut.idx_reg), 32'h0);
        sb.delete();
        cur    = '{target: 0, digits: 32'h0, en: 8'h0, lz: 1'b0};
        lz_sup = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_cyc(FRM + 10);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
